// File: rtl/uart_rx_buf_if.sv
// uart_rx_buf_if: byte stream from the UART receive buffer to its consumer.
// Signals:
//   out_data   head byte of the receive FIFO (0x00 when empty)
//   out_valid  FIFO non-empty
//   in_ready   consumer takes the head byte on out_valid & in_ready
//   out_count  bytes currently held
// master = receive buffer side, slave = consumer side.
interface uart_rx_buf_if #(
    parameter int fifo_depth = 16
);
    logic [7:0]                  out_data;
    logic                        out_valid;
    logic                        in_ready;
    logic [$clog2(fifo_depth):0] out_count;
    modport master (output out_data, out_valid, out_count, input in_ready);
    modport slave (input out_data, out_valid, out_count, output in_ready);
endinterface

// File: rtl/uart_rx_buf.sv
// uart_rx_buf: 8N1 UART receiver with an oversampling FSM feeding a first-word-fall-through FIFO.
// Ports:
//   clk            system clock
//   resetn         synchronous active-low reset
//   in_rx          asynchronous serial line, idle high
//   rx_if          byte stream out (data/valid/ready/count)
//   out_frame_err  one-cycle pulse when a stop bit samples low
//   out_overflow   one-cycle pulse when a good byte is dropped on a full FIFO
module uart_rx_buf #(
    parameter int clocks_per_bit = 4,
    parameter int fifo_depth     = 16
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          in_rx,
    uart_rx_buf_if.master rx_if,
    output logic          out_frame_err,
    output logic          out_overflow
);
    localparam int CW = $clog2(clocks_per_bit);
    localparam int AW = $clog2(fifo_depth);
    localparam logic [CW-1:0] HALF_M1 = CW'(clocks_per_bit / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(clocks_per_bit - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;
    state_t        state_q, state_d;
    logic          s1_q, rx_s_q;
    logic [CW-1:0] cyc_q, cyc_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d, ferr_q, ferr_d, ovf_q, ovf_d;
    logic [7:0]    mem [fifo_depth];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q, count_d;
    logic          pop, full, wr_en, stop_smp;
    always_ff @(posedge clk) begin
        if (!resetn) begin
            s1_q    <= 1'b1;
            rx_s_q  <= 1'b1;
            state_q <= IDLE;
            cyc_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovf_q   <= 1'b0;
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            s1_q    <= in_rx;
            rx_s_q  <= s1_q;
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            ovf_q   <= ovf_d;
            wr_q    <= wr_q + AW'(wr_en);
            rd_q    <= rd_q + AW'(pop);
            count_q <= count_d;
        end
    end
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= shift_q;
    end
    always_comb begin
        state_d = state_q;
        cyc_d   = (cyc_q == LAST) ? '0 : cyc_q + CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        case (state_q)
            IDLE: begin
                cyc_d = '0;
                if (!rx_s_q) state_d = START;
            end
            START: begin
                if (cyc_q == HALF_M1) begin
                    cyc_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cyc_q == LAST) begin
                    shift_d = {rx_s_q, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (cyc_q == LAST) state_d = rx_s_q ? IDLE : WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (rx_s_q) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end
    // The received byte is held in shift_q until push_q writes it one cycle after the stop sample.
    always_comb begin
        stop_smp = (state_q == STOP) && (cyc_q == LAST);
        push_d   = stop_smp & rx_s_q;
        ferr_d   = stop_smp & ~rx_s_q;
    end
    // A full FIFO still accepts a push when a pop frees the head in the same cycle.
    always_comb begin
        pop     = rx_if.out_valid & rx_if.in_ready;
        full    = count_q == (AW+1)'(fifo_depth);
        wr_en   = push_q & (~full | pop);
        ovf_d   = push_q & full & ~pop;
        count_d = count_q + (AW+1)'(wr_en) - (AW+1)'(pop);
    end
    assign rx_if.out_valid = count_q != '0;
    assign rx_if.out_count = count_q;
    assign rx_if.out_data  = rx_if.out_valid ? mem[rd_q] : 8'h00;
    assign out_frame_err   = ferr_q;
    assign out_overflow    = ovf_q;
endmodule

// File: tb/tb_uart_rx_buf.sv
// tb_uart_rx_buf: directed self-checking bench for uart_rx_buf.
module tb_uart_rx_buf;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic in_rx = 1'b1;
    logic ferr, ovf;
    int n_chk = 0;
    int n_fail = 0;
    int ferr_cnt = 0;
    int ovf_cnt = 0;
    logic [7:0] got [$];
    uart_rx_buf_if #(.fifo_depth(16)) bus ();
    uart_rx_buf #(.clocks_per_bit(4), .fifo_depth(16)) dut (
        .clk(clk),
        .resetn(resetn),
        .in_rx(in_rx),
        .rx_if(bus.master),
        .out_frame_err(ferr),
        .out_overflow(ovf)
    );
    always #5 clk = ~clk;
    always @(negedge clk) begin
        ferr_cnt <= ferr_cnt + int'(ferr);
        ovf_cnt  <= ovf_cnt + int'(ovf);
        if (bus.out_valid && bus.in_ready) got.push_back(bus.out_data);
    end
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask
    task automatic send_byte(input logic [7:0] b, input logic stop);
        logic [9:0] frame;
        frame = {stop, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            in_rx = frame[i];
            ticks(4);
        end
        in_rx = 1'b1;
    endtask
    task automatic drain();
        bus.in_ready = 1'b1;
        for (int i = 0; i < 200 && bus.out_count != 0; i++) tick();
        check("drain_empty", 32'(bus.out_count), 0);
    endtask
    initial begin
        int f0, o0;
        logic [7:0] exp_q [$];
        bus.in_ready = 1'b1;
        ticks(3);
        check("rst_valid", 32'(bus.out_valid), 0);
        check("rst_count", 32'(bus.out_count), 0);
        check("rst_data", 32'(bus.out_data), 0);
        check("rst_ferr", 32'(ferr), 0);
        check("rst_ovf", 32'(ovf), 0);
        resetn = 1'b1;
        ticks(3);
        // single frame: start driven after edge P, t0 = P+1, push visible after t0+41
        got.delete();
        send_byte(8'hA5, 1'b1);
        tick();
        check("single_early", 32'(bus.out_valid), 0);
        tick();
        check("single_valid", 32'(bus.out_valid), 1);
        check("single_data", 32'(bus.out_data), 32'h A5);
        check("single_count", 32'(bus.out_count), 1);
        tick();
        check("single_popped", 32'(bus.out_valid), 0);
        check("single_count0", 32'(bus.out_count), 0);
        check("single_got_n", 32'(got.size()), 1);
        if (got.size() > 0) check("single_got", 32'(got[0]), 32'h A5);
        check("single_ferr", 32'(ferr_cnt), 0);
        check("single_ovf", 32'(ovf_cnt), 0);
        // back-to-back frames with no idle gap
        got.delete();
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        send_byte(8'h3C, 1'b1);
        ticks(8);
        exp_q = '{8'h00, 8'hFF, 8'h3C};
        check("b2b_n", 32'(got.size()), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) check($sformatf("b2b_%0d", i), 32'(got[i]), 32'(exp_q[i]));
        check("b2b_ferr", 32'(ferr_cnt), 0);
        // one-cycle glitch
        got.delete();
        in_rx = 1'b0;
        tick();
        in_rx = 1'b1;
        ticks(50);
        check("glitch_push", 32'(got.size()), 0);
        check("glitch_count", 32'(bus.out_count), 0);
        check("glitch_ferr", 32'(ferr_cnt), 0);
        // framing error followed by a break, then a good byte
        got.delete();
        f0 = ferr_cnt;
        send_byte(8'h55, 1'b0);
        in_rx = 1'b0;
        ticks(20);
        in_rx = 1'b1;
        ticks(4);
        send_byte(8'h12, 1'b1);
        ticks(8);
        check("ferr_pulses", 32'(ferr_cnt - f0), 1);
        check("ferr_n", 32'(got.size()), 1);
        if (got.size() > 0) check("ferr_next", 32'(got[0]), 32'h12);
        // overflow: 17 bytes into a 16-deep FIFO with no consumer
        got.delete();
        bus.in_ready = 1'b0;
        o0 = ovf_cnt;
        for (int i = 1; i <= 17; i++) send_byte(8'(i), 1'b1);
        ticks(4);
        check("ovf_count", 32'(bus.out_count), 16);
        check("ovf_pulses", 32'(ovf_cnt - o0), 1);
        check("ovf_head", 32'(bus.out_data), 32'h01);
        // full FIFO: pop in the very cycle the next byte is written
        send_byte(8'h12, 1'b1);
        tick();
        bus.in_ready = 1'b1;
        tick();
        bus.in_ready = 1'b0;
        ticks(2);
        check("fullpop_count", 32'(bus.out_count), 16);
        check("fullpop_ovf", 32'(ovf_cnt - o0), 1);
        drain();
        check("ovf_drain_n", 32'(got.size()), 17);
        for (int i = 0; i < 16 && i < got.size(); i++) check($sformatf("ovf_order_%0d", i), 32'(got[i]), i + 1);
        if (got.size() > 16) check("ovf_last", 32'(got[16]), 32'h12);
        // reset during data bit 4 of 0xC3 with a byte already queued
        got.delete();
        bus.in_ready = 1'b0;
        send_byte(8'h99, 1'b1);
        ticks(3);
        check("pre_rst_count", 32'(bus.out_count), 1);
        in_rx = 1'b0;
        ticks(4);
        for (int i = 0; i < 5; i++) begin
            in_rx = 1'((8'hC3 >> i) & 8'h01);
            ticks(i == 4 ? 2 : 4);
        end
        resetn = 1'b0;
        in_rx = 1'b1;
        ticks(2);
        check("mrst_valid", 32'(bus.out_valid), 0);
        check("mrst_count", 32'(bus.out_count), 0);
        check("mrst_data", 32'(bus.out_data), 0);
        check("mrst_ferr", 32'(ferr), 0);
        check("mrst_ovf", 32'(ovf), 0);
        resetn = 1'b1;
        ticks(50);
        check("mrst_nopush", 32'(bus.out_count), 0);
        bus.in_ready = 1'b1;
        send_byte(8'h7E, 1'b1);
        ticks(8);
        check("mrst_next_n", 32'(got.size()), 1);
        if (got.size() > 0) check("mrst_next", 32'(got[0]), 32'h7E);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
